// File: rtl/mac_operand_sequencer.sv
// Operand FIFO and vector framer feeding an 8x8 MAC; one result per vector.
// Optional feature macro MAC_SEQ_OVF_EN adds res_ovf from a 24-bit shadow sum.
module mac_operand_sequencer #(
    parameter int DEPTH   = 4,
    parameter int MAX_LEN = 255,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_a,
    input  logic [7:0]    in_b,
    input  logic          in_last,
    output logic [7:0]    mac_a,
    output logic [7:0]    mac_b,
    output logic          mac_clr,
    input  logic [15:0]   acc_in,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [15:0]   res_data,
    output logic [CW-1:0] res_count,
    output logic          res_trunc
`ifdef MAC_SEQ_OVF_EN
    ,
    output logic          res_ovf
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN,
        CAPTURE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [16:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          pop_end;
    logic          capture;
    logic [7:0]    hd_a;
    logic [7:0]    hd_b;
    logic          hd_last;
    logic [CW-1:0] len;
    logic [CW-1:0] len_nx;
    logic          trunc_flag;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;

    assign {hd_a, hd_b, hd_last} = mem[rd_ptr[AW-1:0]];

    assign len_nx = len + CW'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_a, in_b, in_last};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        pop_end  = 1'b0;
        capture  = 1'b0;
        unique case (state)
            CLEAR: begin
                state_nx = RUN;
            end
            RUN: begin
                // An empty FIFO is a bubble; the vector simply waits.
                if (!empty) begin
                    pop = 1'b1;
                    if (hd_last || len_nx == CW'(MAX_LEN)) begin
                        pop_end  = 1'b1;
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nx = CAPTURE;
            end
            CAPTURE: begin
                if (!res_valid || res_ready) begin
                    capture  = 1'b1;
                    state_nx = CLEAR;
                end
            end
            default: begin
                state_nx = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mac_a      <= '0;
            mac_b      <= '0;
            mac_clr    <= 1'b1;
            len        <= '0;
            trunc_flag <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_count  <= '0;
            res_trunc  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            // Zero operands on every non-pop cycle keep acc frozen.
            mac_a   <= pop ? hd_a : 8'd0;
            mac_b   <= pop ? hd_b : 8'd0;
            mac_clr <= capture;
            if (pop) begin
                len <= len_nx;
            end else if (capture) begin
                len <= '0;
            end
            if (pop_end) begin
                trunc_flag <= !hd_last;
            end
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= acc_in;
                res_count <= len;
                res_trunc <= trunc_flag;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef MAC_SEQ_OVF_EN
    logic [15:0] prod;
    logic [23:0] shadow;

    assign prod = {8'd0, hd_a} * {8'd0, hd_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            res_ovf <= 1'b0;
        end else begin
            if (pop) begin
                shadow <= shadow + {8'd0, prod};
            end else if (capture) begin
                shadow <= '0;
            end
            if (capture) begin
                res_ovf <= (shadow > 24'h00FFFF);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomized bench for mac_operand_sequencer with a behavioural MAC and a
// vector-level reference model (sums, counts, truncation, operand order).
module tb_mac_operand_sequencer;

    localparam int DEPTH = 4;
    localparam int MAXL  = 3;
    localparam int CW    = $clog2(MAXL + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_a = 8'd0;
    logic [7:0]    in_b = 8'd0;
    logic          in_last = 1'b0;
    logic [7:0]    mac_a;
    logic [7:0]    mac_b;
    logic          mac_clr;
    logic [15:0]   acc = 16'd0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [15:0]   res_data;
    logic [CW-1:0] res_count;
    logic          res_trunc;
`ifdef MAC_SEQ_OVF_EN
    logic          res_ovf;
`endif

    int total = 0;
    int bad = 0;
    int rdy_mode = 0;

    typedef struct {
        logic [15:0] data;
        int          cnt;
        logic        trunc;
        logic        ovf;
    } res_t;

    res_t        exp_q[$];
    logic [15:0] bus_q[$];
    int          cur_sum = 0;
    int          cur_cnt = 0;

    mac_operand_sequencer #(
        .DEPTH   (DEPTH),
        .MAX_LEN (MAXL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_clr   (mac_clr),
        .acc_in    (acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_count (res_count),
        .res_trunc (res_trunc)
`ifdef MAC_SEQ_OVF_EN
        ,
        .res_ovf   (res_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural 8-bit MAC, cleared by mac_clr.
    always @(posedge clk) begin
        if (mac_clr) begin
            acc <= 16'd0;
        end else begin
            acc <= acc + 16'(mac_a) * 16'(mac_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] a, input logic [7:0] b,
                              input logic last);
        res_t r;
        bus_q.push_back({a, b});
        cur_sum += int'(a) * int'(b);
        cur_cnt++;
        if (last || cur_cnt == MAXL) begin
            r.data  = cur_sum[15:0];
            r.cnt   = cur_cnt;
            r.trunc = !last;
            r.ovf   = (cur_sum > 65535);
            exp_q.push_back(r);
            cur_sum = 0;
            cur_cnt = 0;
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        bus_q.delete();
        cur_sum = 0;
        cur_cnt = 0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic last, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_rdy", 32'(in_ready), 32'd1);
        model_push(a, b, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 100);
        chk({tag, "_seen"}, 32'(res_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_res", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // Consumer, scoreboard and operand-order monitor.
    initial begin
        res_t        e;
        logic [15:0] bw;
        logic        hold_prev;
        logic [31:0] hold_val;
        hold_prev = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                case (rdy_mode)
                    0:       res_ready = 1'b1;
                    1:       res_ready = 1'b0;
                    default: res_ready = 1'($urandom_range(0, 1));
                endcase
                if (mac_a != 8'd0 || mac_b != 8'd0) begin
                    chk("bus_avail", 32'(bus_q.size() != 0), 32'd1);
                    if (bus_q.size() != 0) begin
                        bw = bus_q.pop_front();
                        chk("bus_pair", 32'({mac_a, mac_b}), 32'(bw));
                    end
                end
                if (hold_prev) begin
                    chk("res_hold",
                        32'({res_valid, res_trunc, res_count, res_data}),
                        hold_val);
                end
                hold_prev = res_valid && !res_ready;
                hold_val  = 32'({res_valid, res_trunc, res_count, res_data});
                if (res_valid && res_ready) begin
                    chk("res_avail", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("res_data", 32'(res_data), 32'(e.data));
                        chk("res_count", 32'(res_count), 32'(e.cnt));
                        chk("res_trunc", 32'(res_trunc), 32'(e.trunc));
`ifdef MAC_SEQ_OVF_EN
                        chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
`endif
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        int         len;
        int         gap;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mac_clr", 32'(mac_clr), 32'd1);
        chk("rst_mac_ab", 32'({mac_a, mac_b}), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res", 32'({res_trunc, res_count, res_data}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_clr", 32'(mac_clr), 32'd1);
        chk("rel_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("rel_clr_off", 32'(mac_clr), 32'd0);

        // 1: back-to-back vector
        rdy_mode = 0;
        send(8'd2, 8'd4, 1'b0, 0);
        send(8'd4, 8'd4, 1'b0, 0);
        send(8'd3, 8'd5, 1'b1, 0);
        wait_res("t1");
        chk("t1_data", 32'(res_data), 32'h27);
        chk("t1_count", 32'(res_count), 32'd3);
        chk("t1_clr", 32'(mac_clr), 32'd1);
        @(negedge clk);
        chk("t1_pulse", 32'(res_valid), 32'd0);
        chk("t1_clr_off", 32'(mac_clr), 32'd0);
        wait_idle();

        // 2: same vector with input gaps
        send(8'd2, 8'd4, 1'b0, 0);
        send(8'd4, 8'd4, 1'b0, 3);
        send(8'd3, 8'd5, 1'b1, 3);
        wait_res("t2");
        chk("t2_data", 32'(res_data), 32'h27);
        wait_idle();

        // 3: back-pressured results
        rdy_mode = 1;
        send(8'd1, 8'd1, 1'b0, 0);
        send(8'd2, 8'd2, 1'b1, 0);
        send(8'd3, 8'd3, 1'b1, 0);
        wait_res("t3");
        chk("t3_first", 32'(res_data), 32'd5);
        send(8'd7, 8'd7, 1'b0, 0);
        send(8'd7, 8'd7, 1'b0, 0);
        send(8'd7, 8'd7, 1'b0, 0);
        send(8'd7, 8'd7, 1'b1, 0);
        repeat (4) @(negedge clk);
        chk("t3_full", 32'(in_ready), 32'd0);
        chk("t3_stall_ab", 32'({mac_a, mac_b}), 32'd0);
        chk("t3_hold", 32'(res_data), 32'd5);
        rdy_mode = 0;
        wait_idle();

        // 4: forced termination at MAX_LEN
        for (int i = 0; i < 5; i++) begin
            send(8'd1, 8'd1, 1'(i == 4), 0);
        end
        wait_res("t4");
        chk("t4_count", 32'(res_count), 32'd3);
        chk("t4_trunc", 32'(res_trunc), 32'd1);
        wait_idle();

        // 5: 16-bit wrap
        send(8'd255, 8'd255, 1'b0, 0);
        send(8'd255, 8'd255, 1'b1, 0);
        wait_res("t5a");
        chk("t5a_data", 32'(res_data), 32'hFC02);
`ifdef MAC_SEQ_OVF_EN
        chk("t5a_ovf", 32'(res_ovf), 32'd1);
`endif
        wait_idle();
        send(8'd255, 8'd255, 1'b1, 0);
        wait_res("t5b");
        chk("t5b_data", 32'(res_data), 32'hFE01);
`ifdef MAC_SEQ_OVF_EN
        chk("t5b_ovf", 32'(res_ovf), 32'd0);
`endif
        wait_idle();

        // 6: reset mid-vector
        send(8'd5, 8'd5, 1'b0, 0);
        send(8'd6, 8'd6, 1'b0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_flush();
        #1;
        chk("t6_clr", 32'(mac_clr), 32'd1);
        chk("t6_ready", 32'(in_ready), 32'd0);
        chk("t6_ab", 32'({mac_a, mac_b}), 32'd0);
        chk("t6_res", 32'({res_valid, res_trunc, res_count, res_data}), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rel_clr", 32'(mac_clr), 32'd1);
        send(8'd2, 8'd4, 1'b1, 0);
        wait_res("t6");
        chk("t6_data", 32'(res_data), 32'd8);
        chk("t6_count", 32'(res_count), 32'd1);
        wait_idle();

        // Randomized vectors with random gaps and consumer stalls
        rdy_mode = 2;
        for (int v = 0; v < 40; v++) begin
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                a = ($urandom_range(0, 3) == 0) ? 8'd255
                                                : 8'($urandom_range(1, 255));
                b = ($urandom_range(0, 3) == 0) ? 8'd255
                                                : 8'($urandom_range(1, 255));
                gap = ($urandom_range(0, 3) == 0)
                      ? int'($urandom_range(1, 3)) : 0;
                send(a, b, 1'(i == len - 1), gap);
            end
        end
        rdy_mode = 0;
        wait_idle();
        chk("bus_left", 32'(bus_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
Upstream feeder for the 8-bit MAC unit (a, b in; 16-bit acc out; acc <= acc + a*b every clock; cleared by its rst input). Buffers incoming operand pairs in a small FIFO and streams them into the MAC one pair per clock. Frames variable-length dot-product vectors, drives the MAC clear between vectors, and reads back acc to present one result per vector through a valid/ready port.

Parameters:
DEPTH, 4, operand FIFO depth in pairs; power of 2, at least 2
MAX_LEN, 255, maximum pairs per vector before forced termination; CW = $clog2(MAX_LEN+1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept a pair (= !full); forced 0 while rst=1
in_a  in  8  operand a
in_b  in  8  operand b
in_last  in  1  pair is the final element of its vector
mac_a  out  8  registered operand to MAC a
mac_b  out  8  registered operand to MAC b
mac_clr  out  1  registered, drives MAC rst
acc_in  in  16  MAC acc output
res_valid  out  1  result available
res_ready  in  1  result consumer accepts
res_data  out  16  vector sum (mod 2^16)
res_count  out  CW  pairs accumulated in the vector
res_trunc  out  1  vector ended by MAX_LEN, not in_last

Behaviour:
- Reset (async assert, sync release): state=CLEAR, mac_clr=1, mac_a=mac_b=0, FIFO empty, res_valid=0, res_data=0, res_count=0, res_trunc=0, len counter=0.
- Push: in_valid && in_ready stores {a, b, last}. No push when full, including a same-cycle pop (no look-through).
- Operands are registered. A pair popped at edge k is on mac_a/mac_b during cycle k. acc_in includes its product after edge k+1.
- Bubble: any cycle without a pop drives mac_a=mac_b=0, so acc is unchanged.
- States:
  - CLEAR: mac_clr=1, operands 0. Next edge: mac_clr<=0, go to RUN.
  - RUN: if FIFO non-empty, pop, drive pair, len<=len+1.
    - Popped last=1, or len+1==MAX_LEN: go to DRAIN. Set the trunc flag when the end came from MAX_LEN with last=0.
    - FIFO empty: bubble, stay in RUN. Vector continues; no timeout.
  - DRAIN: operands 0 for one cycle while the last product lands. Go to CAPTURE.
  - CAPTURE: operands 0.
    - If !res_valid || res_ready: res_data<=acc_in, res_count<=len, res_trunc<=flag, res_valid<=1, len<=0, mac_clr<=1, go to CLEAR.
    - Otherwise stall in CAPTURE. acc stays frozen by the zero operands.
- Result port: res_valid holds, with data stable, until the res_valid && res_ready handshake. res_valid deasserts after acceptance unless a new capture happens on the same edge; a new capture overwrites the accepted slot.
- Pipelining: the FIFO keeps accepting input during DRAIN, CAPTURE and CLEAR. The pair following a last is not popped until RUN.
- Minimum vector period is len+3 cycles (DRAIN, CAPTURE, CLEAR).
- Arithmetic: res_data equals the MAC's 16-bit wrapped sum. Unsigned operands.
- Reset mid-vector: discards the FIFO, partial sum and pending result. MAC cleared via mac_clr=1.
- A forced-terminated vector's remaining pairs (up to their last) start a new vector.

Optional Feature:
MAC_SEQ_OVF_EN
- Defined: adds output res_ovf (1 bit). A 24-bit shadow sum accumulates each driven product, reset with len. res_ovf is captured with res_data, set when the shadow sum > 16'hFFFF, and reset to 0.
- Undefined: no port, no shadow logic; behaviour is otherwise identical.

Test Plan:
1. Reset, then push (2,4), (4,4), (3,5, last=1) back-to-back with res_ready=1 -> res_data=0x0027 (39), res_count=3, res_trunc=0, exactly one res_valid pulse; mac_clr high for one cycle afterwards.
2. Same vector with in_valid low for 3 cycles between pairs -> mac_a=mac_b=0 during the gaps; result is still 0x0027, count 3.
3. Two vectors {(1,1),(2,2) last} and {(3,3) last} with res_ready=0 until 10 cycles after the first res_valid -> first result 5 held stable, state stalls in CAPTURE, in_ready drops at DEPTH. After release, second result 9; no data lost.
4. MAX_LEN=3, push five pairs of (1,1) with last only on the fifth -> result 3, count 3, trunc=1; then result 2, count 2, trunc=0.
5. Vector (255,255), (255,255, last) -> res_data=0xFC02; with MAC_SEQ_OVF_EN, res_ovf=1. Single (255,255) -> 0xFE01, res_ovf=0.
6. Assert rst for one cycle mid-vector after 2 pairs -> outputs at reset values immediately (mac_clr=1). Then vector (2,4, last) -> res_data=8, count 1.
